// File: rtl/cb_command_issuer_pkg.sv
// Shared constants, FSM state type and severity helpers for the circuit-breaker command issuer.
package cb_command_issuer_pkg;

  // Circuit-breaker modes driven to the order book.
  localparam logic [1:0] CB_NORMAL   = 2'b00;
  localparam logic [1:0] CB_THROTTLE = 2'b01;
  localparam logic [1:0] CB_WIDEN    = 2'b10;
  localparam logic [1:0] CB_PAUSE    = 2'b11;

  // ML classifier anomaly classes.
  localparam logic [1:0] ML_NORMAL          = 2'b00;
  localparam logic [1:0] ML_QUOTE_STUFFING  = 2'b01;
  localparam logic [1:0] ML_ORDER_IMBALANCE = 2'b10;
  localparam logic [1:0] ML_FLASH_CRASH     = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StArming,
    StIssue,
    StHold
  } cb_state_e;

  // Each anomaly class commands the breaker mode of matching severity.
  function automatic logic [1:0] class_to_mode(input logic [1:0] cls);
    logic [1:0] mode;
    unique case (cls)
      ML_NORMAL:          mode = CB_NORMAL;
      ML_QUOTE_STUFFING:  mode = CB_THROTTLE;
      ML_ORDER_IMBALANCE: mode = CB_WIDEN;
      default:            mode = CB_PAUSE;
    endcase
    return mode;
  endfunction

  // Severity rises with the encoding: pause > widen > throttle > normal.
  function automatic logic sev_gt(input logic [1:0] a, input logic [1:0] b);
    return a > b;
  endfunction

endpackage

// File: rtl/cb_command_issuer_if.sv
// Detection input, book feedback and breaker command bundle of the command issuer.
interface cb_command_issuer_if;
  logic       ml_valid;
  logic [1:0] ml_class;
  logic [7:0] ml_conf;
  logic       cb_active_fb;
  logic [1:0] cb_state_fb;
  logic [1:0] cb_mode;
  logic [7:0] cb_param;
  logic       cb_load;
  logic [7:0] issue_count;
  logic       busy;

  // Environment side: classifier plus order book.
  modport master (
    output ml_valid, ml_class, ml_conf, cb_active_fb, cb_state_fb,
    input  cb_mode, cb_param, cb_load, issue_count, busy
  );

  // Issuer side.
  modport slave (
    input  ml_valid, ml_class, ml_conf, cb_active_fb, cb_state_fb,
    output cb_mode, cb_param, cb_load, issue_count, busy
  );
endinterface

// File: rtl/cb_streak_tracker.sv
// Candidate class, consecutive-detection streak and peak confidence of the current candidate.
// Outputs expose the candidate as updated by this cycle's detection; i_clear only zeroes the
// stored state so the detection that triggers an issue is consumed by it.
// CB_CLEAR_EN: NORMAL detections above the confidence floor build their own streak.
module cb_streak_tracker
  import cb_command_issuer_pkg::*;
#(
  parameter int unsigned CONF_MIN = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic [1:0] i_class,
  input  logic [7:0] i_conf,
  input  logic       i_clear,
  output logic [1:0] o_class,
  output logic [3:0] o_streak,
  output logic [7:0] o_param
);

  localparam logic [7:0] ConfMin = 8'(CONF_MIN);

  logic [1:0] r_class;
  logic [3:0] r_streak;
  logic [7:0] r_param;
  logic       w_qual;

  // Streak update from this cycle's detection.
  always_comb begin
    o_class  = r_class;
    o_streak = r_streak;
    o_param  = r_param;
`ifdef CB_CLEAR_EN
    w_qual   = i_valid && (i_conf >= ConfMin);
`else
    w_qual   = i_valid && (i_conf >= ConfMin) && (i_class != ML_NORMAL);
`endif
    if (i_valid) begin
      if (!w_qual) begin
        o_streak = 4'd0;
      end else if ((i_class == r_class) && (r_streak != 4'd0)) begin
        o_streak = (r_streak == 4'd15) ? r_streak : r_streak + 4'd1;
        o_param  = (i_conf > r_param) ? i_conf : r_param;
      end else begin
        o_class  = i_class;
        o_streak = 4'd1;
        o_param  = i_conf;
      end
    end
  end

  // Candidate registers; cleared on reset and when the candidate is issued.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_class  <= ML_NORMAL;
      r_streak <= 4'd0;
      r_param  <= 8'd0;
    end else begin
      r_class  <= o_class;
      r_streak <= o_streak;
      r_param  <= o_param;
    end
  end

endmodule

// File: rtl/cb_command_issuer.sv
// Circuit-breaker command issuer: filters ML detections, confirms streaks, ranks severity and
// enforces a cooldown before driving cb_mode/cb_param/cb_load to the order book.
// Optional macro CB_CLEAR_EN enables early release (mode NORMAL) from confirmed NORMAL streaks.
module cb_command_issuer
  import cb_command_issuer_pkg::*;
#(
  parameter int unsigned CONF_MIN  = 64,
  parameter int unsigned CONFIRM_N = 2,
  parameter int unsigned COOLDOWN  = 16
) (
  input logic               clk,
  input logic               rst,
  cb_command_issuer_if.slave bus
);

  localparam logic [3:0] ConfirmN = 4'(CONFIRM_N);
  localparam logic [7:0] Cooldown = 8'(COOLDOWN);

  cb_state_e  r_state;
  cb_state_e  w_state_next;
  logic [1:0] r_cb_mode;
  logic [7:0] r_cb_param;
  logic [7:0] r_issue_count;
  logic [7:0] r_cool;

  logic       w_valid;
  logic       w_clear;
  logic [1:0] w_cand_class;
  logic [3:0] w_streak;
  logic [7:0] w_cand_param;
  logic [1:0] w_cand_mode;
  logic       w_confirm;
  logic       w_fb_ok;
  logic       w_hold_ok;
  logic       w_permit_raise;
  logic       w_permit_clear;
  logic       w_permit;
  logic [1:0] w_issue_mode;
  logic [7:0] w_issue_param;

  // Detections arriving during the issue cycle are dropped.
  assign w_valid = bus.ml_valid && (r_state != StIssue);
  assign w_clear = (w_state_next == StIssue);

  cb_streak_tracker #(
    .CONF_MIN (CONF_MIN)
  ) u_streak (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (w_valid),
    .i_class  (bus.ml_class),
    .i_conf   (bus.ml_conf),
    .i_clear  (w_clear),
    .o_class  (w_cand_class),
    .o_streak (w_streak),
    .o_param  (w_cand_param)
  );

  // Issue permission for the candidate as it stands after this cycle's detection.
  always_comb begin
    w_cand_mode    = class_to_mode(w_cand_class);
    w_confirm      = (w_streak != 4'd0) &&
                     ((w_cand_class == ML_FLASH_CRASH) || (w_streak >= ConfirmN));
    w_fb_ok        = !bus.cb_active_fb || sev_gt(w_cand_mode, bus.cb_state_fb);
    w_hold_ok      = (r_state != StHold) || sev_gt(w_cand_mode, r_cb_mode);
    w_permit_raise = w_confirm && (w_cand_mode != CB_NORMAL) && w_fb_ok && w_hold_ok;
`ifdef CB_CLEAR_EN
    w_permit_clear = (w_streak >= ConfirmN) && (w_cand_class == ML_NORMAL) &&
                     bus.cb_active_fb && (r_state != StHold);
`else
    w_permit_clear = 1'b0;
`endif
    w_permit       = w_permit_raise || w_permit_clear;
    w_issue_mode   = w_permit_raise ? w_cand_mode : CB_NORMAL;
    w_issue_param  = w_permit_raise ? w_cand_param : 8'd0;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_permit)                 w_state_next = StIssue;
        else if (w_streak != 4'd0)    w_state_next = StArming;
      end
      StArming: begin
        if (w_streak == 4'd0)         w_state_next = StIdle;
        else if (w_permit)            w_state_next = StIssue;
      end
      StIssue:                        w_state_next = StHold;
      StHold: begin
        if (w_permit)                 w_state_next = StIssue;
        else if (r_cool <= 8'd1)      w_state_next = (w_streak != 4'd0) ? StArming : StIdle;
      end
      default:                        w_state_next = StIdle;
    endcase
  end

  // Command, counter and cooldown registers; loaded on entry to the issue cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cb_mode     <= CB_NORMAL;
      r_cb_param    <= 8'd0;
      r_issue_count <= 8'd0;
      r_cool        <= 8'd0;
    end else begin
      if (w_state_next == StIssue) begin
        r_cb_mode     <= w_issue_mode;
        r_cb_param    <= w_issue_param;
        r_issue_count <= (r_issue_count == 8'hff) ? r_issue_count : r_issue_count + 8'd1;
      end
      if (r_state == StIssue)     r_cool <= Cooldown;
      else if (r_state == StHold) r_cool <= r_cool - 8'd1;
    end
  end

  // FSM outputs.
  always_comb begin
    bus.cb_mode     = r_cb_mode;
    bus.cb_param    = r_cb_param;
    bus.cb_load     = (r_state == StIssue);
    bus.issue_count = r_issue_count;
    bus.busy        = (r_state != StIdle);
  end

endmodule

// File: tb/tb_cb_command_issuer.sv
// Directed self-checking bench for cb_command_issuer with default parameters.
module tb_cb_command_issuer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_loads  = 0;
  int   n_b2b    = 0;
  logic prev_load = 1'b0;

  cb_command_issuer_if bus_if ();

  cb_command_issuer #(
    .CONF_MIN  (64),
    .CONFIRM_N (2),
    .COOLDOWN  (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Count load pulses and any back-to-back pair.
  always @(negedge clk) begin
    if (bus_if.cb_load) begin
      n_loads <= n_loads + 1;
      if (prev_load) n_b2b <= n_b2b + 1;
    end
    prev_load <= bus_if.cb_load;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One-cycle detection, sampled at the next rising edge.
  task automatic det(input logic [1:0] cls, input logic [7:0] conf);
    bus_if.ml_valid = 1'b1;
    bus_if.ml_class = cls;
    bus_if.ml_conf  = conf;
    step();
    bus_if.ml_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    step();
    n_checks++; if (bus_if.cb_mode !== 2'd0) begin n_fail++; $display("FAIL reset_mode got=%0d exp=0", bus_if.cb_mode); end
    n_checks++; if (bus_if.cb_param !== 8'd0) begin n_fail++; $display("FAIL reset_param got=%0d exp=0", bus_if.cb_param); end
    n_checks++; if (bus_if.cb_load !== 1'b0) begin n_fail++; $display("FAIL reset_load got=%0d exp=0", bus_if.cb_load); end
    n_checks++; if (bus_if.issue_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus_if.issue_count); end
    n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0d exp=0", bus_if.busy); end
  endtask

  task automatic test_flash_crash();
    det(2'b11, 8'd200);
    n_checks++; if (bus_if.cb_load !== 1'b1) begin n_fail++; $display("FAIL flash_load got=%0d exp=1", bus_if.cb_load); end
    n_checks++; if (bus_if.cb_mode !== 2'b11) begin n_fail++; $display("FAIL flash_mode got=%0d exp=3", bus_if.cb_mode); end
    n_checks++; if (bus_if.cb_param !== 8'd200) begin n_fail++; $display("FAIL flash_param got=%0d exp=200", bus_if.cb_param); end
    n_checks++; if (bus_if.issue_count !== 8'd1) begin n_fail++; $display("FAIL flash_count got=%0d exp=1", bus_if.issue_count); end
    step();
    n_checks++; if (bus_if.cb_load !== 1'b0) begin n_fail++; $display("FAIL flash_load_drop got=%0d exp=0", bus_if.cb_load); end
    n_checks++; if (bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL flash_hold_busy got=%0d exp=1", bus_if.busy); end
    idle(20);
    n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL flash_idle_busy got=%0d exp=0", bus_if.busy); end
  endtask

  task automatic test_confirm();
    int n0;
    det(2'b01, 8'd100);
    n_checks++; if (bus_if.cb_load !== 1'b0) begin n_fail++; $display("FAIL confirm_first_load got=%0d exp=0", bus_if.cb_load); end
    n_checks++; if (bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL confirm_arming_busy got=%0d exp=1", bus_if.busy); end
    det(2'b01, 8'd150);
    n_checks++; if (bus_if.cb_load !== 1'b1) begin n_fail++; $display("FAIL confirm_load got=%0d exp=1", bus_if.cb_load); end
    n_checks++; if (bus_if.cb_mode !== 2'b01) begin n_fail++; $display("FAIL confirm_mode got=%0d exp=1", bus_if.cb_mode); end
    n_checks++; if (bus_if.cb_param !== 8'd150) begin n_fail++; $display("FAIL confirm_param got=%0d exp=150", bus_if.cb_param); end
    n_checks++; if (bus_if.issue_count !== 8'd2) begin n_fail++; $display("FAIL confirm_count got=%0d exp=2", bus_if.issue_count); end
    idle(20);
    n0 = n_loads;
    det(2'b01, 8'd100);
    det(2'b00, 8'd100);
    n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL normal_break_busy got=%0d exp=0", bus_if.busy); end
    idle(2);
    n_checks++; if (n_loads !== n0) begin n_fail++; $display("FAIL normal_break_loads got=%0d exp=%0d", n_loads, n0); end
  endtask

  task automatic test_low_conf();
    int n0;
    n0 = n_loads;
    for (int i = 0; i < 3; i++) det(2'b10, 8'd40);
    n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL lowconf_busy got=%0d exp=0", bus_if.busy); end
    step();
    n_checks++; if (n_loads !== n0) begin n_fail++; $display("FAIL lowconf_loads got=%0d exp=%0d", n_loads, n0); end
  endtask

  task automatic test_cooldown();
    det(2'b01, 8'd100);
    det(2'b01, 8'd100);
    n_checks++; if (bus_if.cb_load !== 1'b1) begin n_fail++; $display("FAIL cool_issue_load got=%0d exp=1", bus_if.cb_load); end
    n_checks++; if (bus_if.issue_count !== 8'd3) begin n_fail++; $display("FAIL cool_issue_count got=%0d exp=3", bus_if.issue_count); end
    step();
    det(2'b01, 8'd100);
    n_checks++; if (bus_if.cb_load !== 1'b0) begin n_fail++; $display("FAIL cool_same1_load got=%0d exp=0", bus_if.cb_load); end
    det(2'b01, 8'd100);
    n_checks++; if (bus_if.cb_load !== 1'b0) begin n_fail++; $display("FAIL cool_same2_load got=%0d exp=0", bus_if.cb_load); end
    idle(2);
    det(2'b11, 8'd90);
    n_checks++; if (bus_if.cb_load !== 1'b1) begin n_fail++; $display("FAIL escalate_load got=%0d exp=1", bus_if.cb_load); end
    n_checks++; if (bus_if.cb_mode !== 2'b11) begin n_fail++; $display("FAIL escalate_mode got=%0d exp=3", bus_if.cb_mode); end
    n_checks++; if (bus_if.cb_param !== 8'd90) begin n_fail++; $display("FAIL escalate_param got=%0d exp=90", bus_if.cb_param); end
    n_checks++; if (bus_if.issue_count !== 8'd4) begin n_fail++; $display("FAIL escalate_count got=%0d exp=4", bus_if.issue_count); end
    idle(20);
  endtask

  task automatic test_downgrade();
    int n0;
    bus_if.cb_active_fb = 1'b1;
    bus_if.cb_state_fb  = 2'b11;
    n0 = n_loads;
    det(2'b01, 8'd100);
    det(2'b01, 8'd100);
    det(2'b11, 8'd200);
    n_checks++; if (bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL downgrade_busy got=%0d exp=1", bus_if.busy); end
    step();
    n_checks++; if (n_loads !== n0) begin n_fail++; $display("FAIL downgrade_loads got=%0d exp=%0d", n_loads, n0); end
    // Book drops to widen: the armed pause candidate now outranks it.
    bus_if.cb_state_fb = 2'b10;
    step();
    n_checks++; if (bus_if.cb_load !== 1'b1) begin n_fail++; $display("FAIL fb_release_load got=%0d exp=1", bus_if.cb_load); end
    n_checks++; if (bus_if.cb_param !== 8'd200) begin n_fail++; $display("FAIL fb_release_param got=%0d exp=200", bus_if.cb_param); end
    n_checks++; if (bus_if.issue_count !== 8'd5) begin n_fail++; $display("FAIL fb_release_count got=%0d exp=5", bus_if.issue_count); end
    bus_if.cb_active_fb = 1'b0;
    bus_if.cb_state_fb  = 2'b00;
    idle(20);
  endtask

  task automatic test_back_to_back();
    det(2'b01, 8'd100);
    det(2'b01, 8'd100);
    n_checks++; if (bus_if.cb_load !== 1'b1) begin n_fail++; $display("FAIL b2b_first_load got=%0d exp=1", bus_if.cb_load); end
    det(2'b11, 8'd220);
    n_checks++; if (bus_if.cb_load !== 1'b0) begin n_fail++; $display("FAIL b2b_dropped_load got=%0d exp=0", bus_if.cb_load); end
    det(2'b11, 8'd230);
    n_checks++; if (bus_if.cb_load !== 1'b1) begin n_fail++; $display("FAIL b2b_second_load got=%0d exp=1", bus_if.cb_load); end
    n_checks++; if (bus_if.cb_param !== 8'd230) begin n_fail++; $display("FAIL b2b_second_param got=%0d exp=230", bus_if.cb_param); end
    n_checks++; if (bus_if.issue_count !== 8'd7) begin n_fail++; $display("FAIL b2b_count got=%0d exp=7", bus_if.issue_count); end
    idle(20);
  endtask

  task automatic test_reset_mid();
    det(2'b10, 8'd100);
    n_checks++; if (bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_arming got=%0d exp=1", bus_if.busy); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (bus_if.cb_mode !== 2'd0) begin n_fail++; $display("FAIL rstmid_mode got=%0d exp=0", bus_if.cb_mode); end
    n_checks++; if (bus_if.cb_param !== 8'd0) begin n_fail++; $display("FAIL rstmid_param got=%0d exp=0", bus_if.cb_param); end
    n_checks++; if (bus_if.issue_count !== 8'd0) begin n_fail++; $display("FAIL rstmid_count got=%0d exp=0", bus_if.issue_count); end
    n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%0d exp=0", bus_if.busy); end
    det(2'b10, 8'd100);
    n_checks++; if (bus_if.cb_load !== 1'b0) begin n_fail++; $display("FAIL rstmid_restart_load got=%0d exp=0", bus_if.cb_load); end
    step();
    n_checks++; if (bus_if.cb_load !== 1'b0) begin n_fail++; $display("FAIL rstmid_later_load got=%0d exp=0", bus_if.cb_load); end
    n_checks++; if (bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_rearm_busy got=%0d exp=1", bus_if.busy); end
  endtask

  initial begin
    bus_if.ml_valid     = 1'b0;
    bus_if.ml_class     = 2'b00;
    bus_if.ml_conf      = 8'd0;
    bus_if.cb_active_fb = 1'b0;
    bus_if.cb_state_fb  = 2'b00;
    test_reset();
    test_flash_crash();
    test_confirm();
    test_low_conf();
    test_cooldown();
    test_downgrade();
    test_back_to_back();
    test_reset_mid();
    step();
    n_checks++; if (n_b2b !== 0) begin n_fail++; $display("FAIL consecutive_loads got=%0d exp=0", n_b2b); end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
